// File: rtl/tag_retire_tracker_if.sv
// Bundle of the configuration, write-back and status signals for tag_retire_tracker.
// The master side drives cfg/wb/clear; the slave side (the tracker) drives the status outputs.
`ifndef NTAG
`define NTAG 8
`endif
`ifndef NTAGW
`define NTAGW 3
`endif

interface tag_retire_tracker_if #(
   parameter int NTAGW = `NTAGW,
   parameter int CNTW  = 16
);
   logic             cfg_valid;
   logic [NTAGW-1:0] cfg_tag;
   logic [CNTW-1:0]  cfg_count;
   logic             wb0_valid;
   logic [NTAGW-1:0] wb0_tag;
   logic             wb1_valid;
   logic [NTAGW-1:0] wb1_tag;
   logic             clear;
   logic [NTAGW-1:0] current_tag;
   logic             all_done;
   logic             err;
   logic [31:0]      stall_cycles;

   modport master (
      output cfg_valid, cfg_tag, cfg_count,
      output wb0_valid, wb0_tag, wb1_valid, wb1_tag, clear,
      input  current_tag, all_done, err, stall_cycles
   );

   modport slave (
      input  cfg_valid, cfg_tag, cfg_count,
      input  wb0_valid, wb0_tag, wb1_valid, wb1_tag, clear,
      output current_tag, all_done, err, stall_cycles
   );
endinterface

// File: rtl/tag_retire_tracker.sv
// In-order tag retirement: counts write-backs per tag and advances current_tag when the head completes.
// Optional stall statistics counter enabled by defining TAG_TRACKER_STATS_EN.
`ifndef NTAG
`define NTAG 8
`endif
`ifndef NTAGW
`define NTAGW 3
`endif

module tag_retire_tracker #(
   parameter int NTAG  = `NTAG,
   parameter int NTAGW = `NTAGW,
   parameter int CNTW  = 16
) (
   input logic                clk,
   input logic                rst,
   tag_retire_tracker_if.slave bus
);
   localparam logic [NTAGW-1:0] LAST = NTAGW'(NTAG - 1);

   logic [CNTW-1:0]  exp_q  [NTAG];
   logic [CNTW-1:0]  exp_d  [NTAG];
   logic [CNTW-1:0]  done_q [NTAG];
   logic [CNTW-1:0]  done_d [NTAG];
   logic [NTAG-1:0]  cfgd_q, cfgd_d;
   logic [NTAGW-1:0] cur_q, cur_d;
   logic             err_q, err_d;
   logic             retire;
   logic             all_done;

   assign all_done = (cur_q == LAST);
   assign retire   = cfgd_q[cur_q] && (done_q[cur_q] == exp_q[cur_q]) && !all_done;

   always_comb begin
      logic [NTAGW-1:0] tt;
      logic             hit0, hit1;
      logic [1:0]       inc;
      logic [CNTW:0]    sum;
      exp_d  = exp_q;
      done_d = done_q;
      cfgd_d = cfgd_q;
      cur_d  = cur_q;
      err_d  = err_q;
      tt     = '0;
      hit0   = 1'b0;
      hit1   = 1'b0;
      inc    = '0;
      sum    = '0;

      // A cfg for an already-retired tag is stale and dropped; a repeat cfg still overwrites.
      if (bus.cfg_valid) begin
         if (bus.cfg_tag < cur_q) begin
            err_d = 1'b1;
         end else begin
            if (cfgd_q[bus.cfg_tag]) err_d = 1'b1;
            exp_d[bus.cfg_tag]  = bus.cfg_count;
            cfgd_d[bus.cfg_tag] = 1'b1;
         end
      end

      if (bus.wb0_valid && (bus.wb0_tag < cur_q || bus.wb0_tag == LAST)) err_d = 1'b1;
      if (bus.wb1_valid && (bus.wb1_tag < cur_q || bus.wb1_tag == LAST)) err_d = 1'b1;

      for (int t = 0; t < NTAG; t++) begin
         tt   = NTAGW'(t);
         hit0 = bus.wb0_valid && (bus.wb0_tag == tt) && (tt >= cur_q) && (tt != LAST);
         hit1 = bus.wb1_valid && (bus.wb1_tag == tt) && (tt >= cur_q) && (tt != LAST);
         inc  = {1'b0, hit0} + {1'b0, hit1};
         sum  = '0;
         if (inc != 2'd0) begin
            sum = {1'b0, done_q[t]} + (CNTW+1)'(inc);
            if (sum[CNTW]) begin
               err_d = 1'b1;
            end else begin
               done_d[t] = sum[CNTW-1:0];
               if (cfgd_d[t] && (sum[CNTW-1:0] > exp_d[t])) err_d = 1'b1;
            end
         end
      end

      // Retiring the head wipes its entry, so a write-back landing on it this cycle is lost.
      if (retire) begin
         cur_d          = cur_q + 1'b1;
         exp_d[cur_q]   = '0;
         done_d[cur_q]  = '0;
         cfgd_d[cur_q]  = 1'b0;
         if ((bus.wb0_valid && bus.wb0_tag == cur_q) ||
             (bus.wb1_valid && bus.wb1_tag == cur_q)) err_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         for (int t = 0; t < NTAG; t++) begin
            exp_q[t]  <= '0;
            done_q[t] <= '0;
         end
         cfgd_q <= '0;
         cur_q  <= '0;
         err_q  <= rst ? 1'b0 : err_q;
      end else begin
         exp_q  <= exp_d;
         done_q <= done_d;
         cfgd_q <= cfgd_d;
         cur_q  <= cur_d;
         err_q  <= err_d;
      end
   end

   assign bus.current_tag = cur_q;
   assign bus.all_done    = all_done;
   assign bus.err         = err_q;

`ifdef TAG_TRACKER_STATS_EN
   logic [31:0] stall_q;

   // Counts cycles where the head is configured but still waiting on write-backs.
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         stall_q <= '0;
      end else if (cfgd_q[cur_q] && !retire && !all_done && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
`else
   assign bus.stall_cycles = '0;
`endif
endmodule
